// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 receiver: state encoding, parameter defaults,
// sample-tick positions inside a bit period and the majority voter.
package rs232_pkg;

  localparam int DATA_BITS_DEF   = 8;
  localparam int OVERSAMPLE_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Tick indices of the three samples voted on in each bit period (M-1, M, M+1).
  function automatic int tick_lo(input int os);
    return os / 2 - 1;
  endfunction

  function automatic int tick_mid(input int os);
    return os / 2;
  endfunction

  function automatic int tick_hi(input int os);
    return os / 2 + 1;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_rx_if.sv
// Byte delivery and error-status bundle between the receiver and its consumer.
interface rs232_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_err;
  logic                 overrun;
  logic                 err_clr;

  modport master (
    output data, data_valid, frame_err, overrun,
    input  data_ready, err_clr
  );

  modport slave (
    input  data, data_valid, frame_err, overrun,
    output data_ready, err_clr
  );
endinterface

// File: rtl/rs232_rx_sampler.sv
// Line synchroniser, per-bit tick counter and three-sample majority voter.
// Emits bit_strobe on the decision tick (M+1) with the voted bit in bit_val.
module rs232_rx_sampler
  import rs232_pkg::*;
#(
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rx_en,
  input  logic rxd,
  input  logic restart,     // current rx_en tick is tick 0 of a start bit
  output logic rxs,
  output logic bit_strobe,
  output logic bit_val
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] TICK_LO   = CNT_W'(tick_lo(OVERSAMPLE));
  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(tick_mid(OVERSAMPLE));
  localparam logic [CNT_W-1:0] TICK_HI   = CNT_W'(tick_hi(OVERSAMPLE));
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   samp_lo_q, samp_lo_d;
  logic                   samp_mid_q, samp_mid_d;

  assign rxs        = sync_q[SYNC_STAGES-1];
  assign bit_strobe = rx_en && (cnt_q == TICK_HI);
  assign bit_val    = majority3(samp_lo_q, samp_mid_q, rxs);

  // Next-state: shift the synchroniser every clk; count ticks and capture samples on rx_en.
  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], rxd};
    cnt_d      = cnt_q;
    samp_lo_d  = samp_lo_q;
    samp_mid_d = samp_mid_q;
    if (rx_en) begin
      if (restart)                cnt_d = CNT_W'(1);
      else if (cnt_q == TICK_LAST) cnt_d = '0;
      else                        cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == TICK_LO)  samp_lo_d  = rxs;
      if (cnt_q == TICK_MID) samp_mid_d = rxs;
    end
  end

  // Sampler registers; the synchroniser resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '1;
      cnt_q      <= '0;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      samp_lo_q  <= samp_lo_d;
      samp_mid_q <= samp_mid_d;
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// 8N1 UART receiver: frame FSM on top of the oversampling sampler, a one-byte
// holding register with valid/ready delivery, and sticky framing/overrun flags.
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          rx_en,
  input  logic          rxd,
  rs232_rx_if.master    bus
);

  localparam int BCNT_W = $clog2(DATA_BITS);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_BITS - 1);

  logic rxs, bit_strobe, bit_val, restart;

  rx_state_e              state_q, state_d;
  logic [BCNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   dlv_q, dlv_d;          // byte completed at the stop decision
  logic                   ferr_set_q, ferr_set_d;

  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   ovr_set;

  rs232_rx_sampler #(
    .OVERSAMPLE  (OVERSAMPLE),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sampler (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_en      (rx_en),
    .rxd        (rxd),
    .restart    (restart),
    .rxs        (rxs),
    .bit_strobe (bit_strobe),
    .bit_val    (bit_val)
  );

  // Frame FSM next-state: start detect, data shift-in, stop check and break hold-off.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    dlv_d      = 1'b0;
    ferr_set_d = 1'b0;
    restart    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_en && !rxs) begin
          state_d = ST_START;
          restart = 1'b1;
        end
      end
      ST_START: begin
        bit_cnt_d = '0;
        if (bit_strobe) state_d = bit_val ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (bit_strobe) begin
          shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BIT_LAST) state_d = ST_STOP;
          else                       bit_cnt_d = bit_cnt_q + BCNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_strobe) begin
          if (bit_val) begin
            state_d = ST_IDLE;
            dlv_d   = 1'b1;
          end else begin
            state_d    = ST_BREAK;
            ferr_set_d = 1'b1;
          end
        end
      end
      ST_BREAK: begin
        if (rx_en && rxs) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding register and sticky flags; a set event outranks err_clr in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_set = 1'b0;
    if (valid_q && bus.data_ready) valid_d = 1'b0;
    if (dlv_q) begin
      if (!valid_q || bus.data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    ferr_d = (ferr_q && !bus.err_clr) || ferr_set_q;
    ovr_d  = (ovr_q  && !bus.err_clr) || ovr_set;
  end

  // All receiver state; reset drops any partial frame and the held byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      dlv_q      <= 1'b0;
      ferr_set_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      dlv_q      <= dlv_d;
      ferr_set_q <= ferr_set_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.data       = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;

endmodule
